// File: rtl/mau_wb_arbiter_if.sv
// mau_wb_arbiter_if: client request/response and Wishbone B4 pipelined bus bundle
interface mau_wb_arbiter_if #(
    parameter int N_CH       = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
);
    localparam int BE_W = DATA_W / 8;
    logic [N_CH-1:0]              req_val;
    logic [N_CH-1:0]              req_we;
    logic [N_CH-1:0]              req_nc;
    logic [N_CH*ADDR_W-1:0]       req_addr;
    logic [N_CH*DATA_W-1:0]       req_wdata;
    logic [N_CH*BE_W-1:0]         req_be;
    logic [N_CH-1:0]              req_ack;
    logic [LINE_WORDS*DATA_W-1:0] ack_data;
    logic                         ack_nc;
    logic                         ack_we;
    logic                         ack_err;
    logic [DATA_W-1:0]            wb_dat_i;
    logic                         wb_ack_i;
    logic                         wb_stall_i;
    logic                         wb_err_i;
    logic [DATA_W-1:0]            wb_dat_o;
    logic [ADDR_W-1:0]            wb_adr_o;
    logic [BE_W-1:0]              wb_sel_o;
    logic                         wb_cyc_o;
    logic                         wb_stb_o;
    logic                         wb_we_o;
    logic                         wb_lock_o;
    modport master (
        input  req_val, req_we, req_nc, req_addr, req_wdata, req_be,
        input  wb_dat_i, wb_ack_i, wb_stall_i, wb_err_i,
        output req_ack, ack_data, ack_nc, ack_we, ack_err,
        output wb_dat_o, wb_adr_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o
    );
    modport slave (
        output req_val, req_we, req_nc, req_addr, req_wdata, req_be,
        output wb_dat_i, wb_ack_i, wb_stall_i, wb_err_i,
        input  req_ack, ack_data, ack_nc, ack_we, ack_err,
        input  wb_dat_o, wb_adr_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o
    );
endinterface

// File: rtl/mau_wb_arbiter.sv
// mau_wb_arbiter: round-robin N-channel cache refill / single-beat access unit on Wishbone B4 pipelined (optional MAU_WB_ERR_EN bus-error termination)
module mau_wb_arbiter #(
    parameter int N_CH       = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input logic              wb_clk_i,
    input logic              wb_rst_i,
    mau_wb_arbiter_if.master bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CW    = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(LINE_WORDS) + 1;
    localparam int OFF   = $clog2(LINE_WORDS * BE_W);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                       state_q;
    logic [CW-1:0]                rr_q, grant_q, gnt_d, idx;
    logic                         gnt_val_d;
    logic                         we_q, nc_q, err_q;
    logic [CNT_W-1:0]             beats_q, issued_q, acked_q, issued_d;
    logic                         cyc_q, stb_q;
    logic [ADDR_W-1:0]            adr_q, req_adr;
    logic [DATA_W-1:0]            dat_q;
    logic [BE_W-1:0]              sel_q;
    logic [N_CH-1:0]              req_ack_q;
    logic [LINE_WORDS*DATA_W-1:0] line_q, line_d, ack_data_q;
    logic                         ack_nc_q, ack_we_q, ack_err_q;
    logic                         accept, err_in, err_any, term, last, line_rd;

`ifdef MAU_WB_ERR_EN
    assign err_in = bus.wb_err_i;
`else
    logic unused_err;
    assign unused_err = bus.wb_err_i;
    assign err_in = 1'b0;
`endif

    // Circular search for the first requesting channel after the last grant
    always_comb begin
        gnt_d = rr_q;
        gnt_val_d = 1'b0;
        idx = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = CW'((int'(rr_q) + i) % N_CH);
            if (!gnt_val_d && bus.req_val[idx]) begin
                gnt_d = idx;
                gnt_val_d = 1'b1;
            end
        end
    end

    // Beat bookkeeping; after an error the beats already issued become the drain limit
    always_comb begin
        accept = stb_q && !bus.wb_stall_i;
        issued_d = issued_q + CNT_W'(accept);
        term = bus.wb_ack_i || err_in;
        err_any = err_q || err_in;
        last = term && (acked_q + CNT_W'(1) >= (err_any ? issued_d : beats_q));
        line_rd = !bus.req_we[gnt_d] && !bus.req_nc[gnt_d];
        req_adr = bus.req_addr[gnt_d*ADDR_W +: ADDR_W];
        line_d = line_q;
        line_d[acked_q[CNT_W-2:0]*DATA_W +: DATA_W] = err_in ? '0 : bus.wb_dat_i;
    end

    // Transaction FSM with registered bus and response outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            rr_q       <= CW'(N_CH - 1);
            grant_q    <= '0;
            we_q       <= 1'b0;
            nc_q       <= 1'b0;
            err_q      <= 1'b0;
            beats_q    <= '0;
            issued_q   <= '0;
            acked_q    <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            req_ack_q  <= '0;
            line_q     <= '0;
            ack_data_q <= '0;
            ack_nc_q   <= 1'b0;
            ack_we_q   <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (gnt_val_d) begin
                    state_q  <= BUS;
                    grant_q  <= gnt_d;
                    rr_q     <= gnt_d;
                    we_q     <= bus.req_we[gnt_d];
                    nc_q     <= bus.req_nc[gnt_d];
                    err_q    <= 1'b0;
                    beats_q  <= line_rd ? CNT_W'(LINE_WORDS) : CNT_W'(1);
                    issued_q <= '0;
                    acked_q  <= '0;
                    adr_q    <= line_rd ? {req_adr[ADDR_W-1:OFF], OFF'(0)} : req_adr;
                    dat_q    <= bus.req_wdata[gnt_d*DATA_W +: DATA_W];
                    sel_q    <= line_rd ? '1 : bus.req_be[gnt_d*BE_W +: BE_W];
                    cyc_q    <= 1'b1;
                    stb_q    <= 1'b1;
                end
                BUS: begin
                    issued_q <= issued_d;
                    stb_q <= stb_q && !err_any && issued_d < beats_q;
                    if (accept && issued_d < beats_q) adr_q <= adr_q + ADDR_W'(BE_W);
                    if (term) begin
                        acked_q <= acked_q + CNT_W'(1);
                        line_q  <= line_d;
                        err_q   <= err_any;
                    end
                    if (last) begin
                        state_q    <= RESP;
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        req_ack_q  <= N_CH'(1) << grant_q;
                        ack_data_q <= line_d;
                        ack_nc_q   <= nc_q;
                        ack_we_q   <= we_q;
                        ack_err_q  <= err_any;
                    end
                end
                RESP: begin
                    req_ack_q <= '0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ack   = req_ack_q;
    assign bus.ack_data  = ack_data_q;
    assign bus.ack_nc    = ack_nc_q;
    assign bus.ack_we    = ack_we_q;
    assign bus.ack_err   = ack_err_q;
    assign bus.wb_dat_o  = dat_q;
    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_sel_o  = sel_q;
    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = stb_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_lock_o = 1'b0;
endmodule

// File: tb/tb_mau_wb_arbiter.sv
// tb_mau_wb_arbiter: scoreboard bench with a pipelined Wishbone slave model
module tb_mau_wb_arbiter;
    localparam int N_CH = 2;
    localparam int LW   = 4;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    typedef struct {
        int           ch;
        logic [127:0] data;
        int           words;
        logic         nc;
        logic         we;
        logic         err;
        int           cyc;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int cyc_n = 0;

    beat_t exp_b[$];
    resp_t exp_r[$];

    int reload[N_CH];
    logic rq_we[N_CH];
    logic rq_nc[N_CH];
    logic [31:0] rq_addr[N_CH];
    logic [31:0] rq_wdata[N_CH];
    logic [3:0] rq_be[N_CH];

    logic [3:0] stall_mask = 4'b0;
    int stall_len = 0;
    int err_beat = -1;
    int acks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    mau_wb_arbiter_if #(.N_CH(N_CH), .ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) bus ();

    mau_wb_arbiter #(.N_CH(N_CH), .ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus.master)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        logic [31:0] l;
        l = {a[31:4], 4'h0} - 32'h1010;
        return 32'hA0 + {30'h0, a[3:2]} + (l << 4);
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Slave model: stalls per schedule, acks (or errs) each accepted beat one cycle later
    logic acc_p = 1'b0;
    logic [31:0] adr_p = '0;
    logic [31:0] adr_hold = '0;
    int bidx = 0, bidx_p = 0, st_cnt = 0;
    always @(negedge clk) begin
        beat_t b;
        bus.wb_ack_i = acc_p && bidx_p != err_beat;
        bus.wb_err_i = acc_p && bidx_p == err_beat;
        bus.wb_dat_i = acc_p ? rd(adr_p) : 32'h0;
        if (acc_p) acks++;
        acc_p = 1'b0;
        bus.wb_stall_i = 1'b0;
        if (!bus.wb_cyc_o) bidx = 0;
        if (bus.wb_cyc_o && bus.wb_stb_o) begin
            if (bidx < 4 && stall_mask[bidx] && st_cnt < stall_len) begin
                if (st_cnt > 0) chk("stall_adr", bus.wb_adr_o, adr_hold);
                adr_hold = bus.wb_adr_o;
                bus.wb_stall_i = 1'b1;
                st_cnt++;
            end else begin
                st_cnt = 0;
                acc_p = 1'b1;
                adr_p = bus.wb_adr_o;
                bidx_p = bidx;
                bidx++;
                if (exp_b.size() == 0) chk("beat_unexp", 1'b1, 1'b0);
                else begin
                    b = exp_b.pop_front();
                    chk("beat_adr", bus.wb_adr_o, b.adr);
                    chk("beat_we", bus.wb_we_o, b.we);
                    chk("beat_sel", bus.wb_sel_o, b.sel);
                    if (b.we) chk("beat_dat", bus.wb_dat_o, b.dat);
                end
            end
        end
    end

    task automatic push_exp(input int ch, input logic we, input logic nc, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be, input int lat,
                            input int errb, input logic resp);
        beat_t b;
        resp_t r;
        logic line;
        logic [31:0] base;
        line = !we && !nc;
        base = {addr[31:4], 4'h0};
        r.data = '0;
        for (int k = 0; k < (line ? LW : 1); k++) begin
            b.adr = line ? base + 32'(4 * k) : addr;
            b.we = we;
            b.sel = line ? 4'hF : be;
            b.dat = wdata;
            exp_b.push_back(b);
            r.data[k*32 +: 32] = (k == errb) ? 32'h0 : rd(b.adr);
        end
        r.ch = ch;
        r.words = line ? LW : 1;
        r.nc = nc;
        r.we = we;
        r.err = errb >= 0;
        r.cyc = lat < 0 ? -1 : cyc_n + lat;
        if (resp) exp_r.push_back(r);
    endtask

    task automatic issue(input int ch, input logic we, input logic nc, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int lat,
                         input int errb, input logic resp);
        push_exp(ch, we, nc, addr, wdata, be, lat, errb, resp);
        rq_we[ch] = we;
        rq_nc[ch] = nc;
        rq_addr[ch] = addr;
        rq_wdata[ch] = wdata;
        rq_be[ch] = be;
        bus.req_we[ch] = we;
        bus.req_nc[ch] = nc;
        bus.req_addr[ch*32 +: 32] = addr;
        bus.req_wdata[ch*32 +: 32] = wdata;
        bus.req_be[ch*4 +: 4] = be;
        bus.req_val[ch] = 1'b1;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int got;
        resp_t r;
        logic [127:0] m;
        got = 0;
        for (int i = 0; i < budget && got < n; i++) begin
            @(negedge clk);
            if (bus.req_ack != '0) begin
                got++;
                if (exp_r.size() == 0) chk("resp_unexp", 128'(bus.req_ack), 128'h0);
                else begin
                    r = exp_r.pop_front();
                    m = (r.words == LW) ? {128{1'b1}} : 128'hFFFF_FFFF;
                    chk("ack_ch", 128'(bus.req_ack), 128'(1) << r.ch);
                    chk("ack_data", bus.ack_data & m, r.data & m);
                    chk("ack_nc", bus.ack_nc, r.nc);
                    chk("ack_we", bus.ack_we, r.we);
                    chk("ack_err", bus.ack_err, r.err);
                    if (r.cyc >= 0) chk("ack_cycle", 128'(cyc_n), 128'(r.cyc));
                    if (reload[r.ch] > 0) begin
                        reload[r.ch]--;
                        push_exp(r.ch, rq_we[r.ch], rq_nc[r.ch], rq_addr[r.ch], rq_wdata[r.ch],
                                 rq_be[r.ch], -1, -1, 1'b1);
                    end else bus.req_val[r.ch] = 1'b0;
                end
            end
        end
        chk("resp_count", 128'(got), 128'(n));
        @(negedge clk);
    endtask

    initial begin
        int a0;
        logic seen;
        for (int c = 0; c < N_CH; c++) reload[c] = 0;
        bus.req_val = '0;
        bus.req_we = '0;
        bus.req_nc = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_be = '0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", bus.wb_cyc_o, 1'b0);
        chk("rst_stb", bus.wb_stb_o, 1'b0);
        chk("rst_we", bus.wb_we_o, 1'b0);
        chk("rst_lock", bus.wb_lock_o, 1'b0);
        chk("rst_adr", bus.wb_adr_o, 32'h0);
        chk("rst_dat", bus.wb_dat_o, 32'h0);
        chk("rst_sel", bus.wb_sel_o, 4'h0);
        chk("rst_req_ack", 128'(bus.req_ack), 128'h0);
        chk("rst_ack_data", bus.ack_data, 128'h0);
        chk("rst_ack_nc", bus.ack_nc, 1'b0);
        chk("rst_ack_we", bus.ack_we, 1'b0);
        chk("rst_ack_err", bus.ack_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        issue(0, 1'b0, 1'b0, 32'h0000_1014, 32'h0, 4'hF, LW + 2, -1, 1'b1);
        wait_acks(1, 50);

        issue(1, 1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 3, -1, 1'b1);
        wait_acks(1, 50);

        reload[0] = 2;
        reload[1] = 2;
        issue(0, 1'b0, 1'b0, 32'h0000_3008, 32'h0, 4'hF, -1, -1, 1'b1);
        issue(1, 1'b0, 1'b1, 32'h0000_4004, 32'h0, 4'hF, -1, -1, 1'b1);
        wait_acks(6, 300);

        stall_mask = 4'b0110;
        stall_len = 3;
        issue(0, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, LW + 2 + 6, -1, 1'b1);
        wait_acks(1, 80);
        stall_mask = 4'b0;

        a0 = acks;
        issue(1, 1'b0, 1'b0, 32'h0000_5000, 32'h0, 4'hF, -1, -1, 1'b0);
        for (int i = 0; i < 50 && acks < a0 + 2; i++) @(negedge clk);
        chk("mid_acks", 128'(acks - a0 >= 2), 128'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cyc", bus.wb_cyc_o, 1'b0);
        chk("midrst_stb", bus.wb_stb_o, 1'b0);
        chk("midrst_req_ack", 128'(bus.req_ack), 128'h0);
        chk("midrst_ack_data", bus.ack_data, 128'h0);
        rst = 1'b0;
        bus.req_val = '0;
        exp_b.delete();
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | (bus.req_ack != '0) | bus.wb_cyc_o;
        end
        chk("midrst_quiet", seen, 1'b0);
        issue(0, 1'b0, 1'b0, 32'h0000_1010, 32'h0, 4'hF, LW + 2, -1, 1'b1);
        wait_acks(1, 50);

`ifdef MAU_WB_ERR_EN
        err_beat = 2;
        issue(0, 1'b0, 1'b0, 32'h0000_1010, 32'h0, 4'hF, LW + 2, 2, 1'b1);
        wait_acks(1, 50);
        err_beat = -1;
`endif

        chk("beats_left", 128'(exp_b.size()), 128'h0);
        chk("resps_left", 128'(exp_r.size()), 128'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
